sysrst_ctrl_combo_multi: RTL and testbench
==========================================

// Module: sysrst_ctrl_combo_multi
//
// PURPOSE
// Parametrised multi-combo key detector, successor to the fixed combo logic.
// - Watches NumKeys debounced-domain key inputs.
// - Supports NumCombos independent combos, each with its own key mask, debounce
//   time, hold (detect) time and action set.
// - Drives system actions: battery disable, EC reset pulse, GSC reset, and
//   interrupt status.
// - Sits behind the register file, which flattens per-combo config into vectors.
//
// PARAMETERS
// NumKeys    5   number of key inputs (pwrb, key0..2, ac_present in the default map)
// NumCombos  4   number of independent combo detectors
// TimerW     16  width of every timer/counter field; max count 2**TimerW-1 cycles
//
// PORTS
// clk_i              in   1                  single clock for all logic
// rst_ni             in   1                  async reset, active-low
// keys_i             in   NumKeys            key levels, 1 = pressed (already inverted/synced)
// combo_sel_i        in   NumCombos*NumKeys  per-combo key mask; all-zero disables the combo
// debounce_timer_i   in   NumCombos*TimerW   per-combo debounce length D
// detect_timer_i     in   NumCombos*TimerW   per-combo hold length T
// combo_action_i     in   NumCombos*4        per combo: [0]=intr [1]=bat_disable [2]=ec_rst [3]=gsc_rst
// ec_rst_pulse_i     in   TimerW             EC reset low-pulse length P
// status_clr_i       in   NumCombos          write-1-to-clear for combo_status_o
// combo_fire_o       out  NumCombos          1-cycle pulse per combo on detection
// combo_status_o     out  NumCombos          sticky detection status (interrupt-enabled combos only)
// intr_o             out  1                  OR of combo_status_o
// bat_disable_o      out  1                  sticky battery disable
// ec_rst_l_o         out  1                  EC reset, active-low pulse
// gsc_rst_o          out  1                  1-cycle GSC reset pulse
//
// BEHAVIOUR
// - Reset values: combo_fire_o=0, combo_status_o=0, intr_o=0, bat_disable_o=0,
//   ec_rst_l_o=1, gsc_rst_o=0. All FSMs reset to IDLE with counters at 0.
// - Active condition for combo i: sel!=0 && (keys_i & sel)==sel.
//   Extra pressed keys outside the mask do not block the combo.
// - Per-combo FSM, counter cnt (TimerW bits):
//   - IDLE: if active -> DEBOUNCE, cnt=0.
//   - DEBOUNCE: if !active -> IDLE; else if cnt==D -> DETECT, cnt=0; else cnt++.
//   - DETECT: if !active -> IDLE; else if cnt==T -> WAIT_REL, fire; else cnt++.
//   - WAIT_REL: if !active -> IDLE. No refire while the combo stays held.
// - Latency: keys first sampled active at edge 0 -> combo_fire_o high in the
//   cycle after edge D+T+2. D=T=0 gives 2 cycles.
// - Counters never wrap: compare-then-increment, and cnt stops at D or T.
// - Config is read live. A sel change that deasserts active returns the FSM to
//   IDLE on the next edge.
// - Actions are registered off the fire pulse, so they are visible 1 cycle
//   after combo_fire_o:
//   - intr: sets combo_status_o[i]. If status_clr_i[i] lands in the same cycle
//     as a set, the set wins.
//   - bat_disable: bat_disable_o=1 until reset.
//   - ec_rst: ec_rst_l_o low for exactly P+1 cycles. A new ec_rst fire during
//     the pulse restarts the count.
//   - gsc_rst: gsc_rst_o high for 1 cycle.
// - Simultaneous fires from several combos OR their actions. No priority.
// - Async reset mid-operation aborts any pulse; outputs go to reset values at once.
//
// CONFIGURATION
// SYSRST_CTRL_COMBO_PRECOND_EN defined:
// - Adds input port precond_timer_i (TimerW).
// - FSMs reset into state PRECOND instead of IDLE.
// - PRECOND: if (keys_i & sel)!=0 -> cnt=0; else if cnt==precond_timer_i -> IDLE;
//   else cnt++.
// - Any return to IDLE from DEBOUNCE, DETECT or WAIT_REL goes to PRECOND instead.
//   A combo therefore arms only after all its keys have been released for
//   precond_timer_i+1 cycles.
// SYSRST_CTRL_COMBO_PRECOND_EN undefined: no PRECOND state and no port;
// behaviour as above.
//
// TESTING
// 1. sel0=0b00011, D=3, T=5, action0=intr; press keys 0,1 at edge 0
//    -> combo_fire_o[0] pulses in cycle 10; combo_status_o[0]=1 and intr_o=1
//       from cycle 11.
// 2. Same setup, release key 1 at cycle 6 -> no fire, FSM back in IDLE.
//    Press again -> the full 10-cycle count restarts.
// 3. action0=ec_rst, P=4, combo fires; fire again 2 cycles into the pulse
//    -> ec_rst_l_o low 7 cycles total (2+5).
// 4. status_clr_i[0]=1 in the same cycle as a new intr set -> status stays 1.
//    Clear alone -> 0 next cycle, intr_o drops.
// 5. Two combos, sel0=0b00001 with bat_disable and sel1=0b00011 with gsc_rst,
//    D=T=0 both; press keys 0,1 together -> both fire in cycle 2,
//    bat_disable_o=1 sticky, gsc_rst_o one pulse.
// 6. PRECOND_EN, precond=3, keys held from reset -> no fire until released
//    4 cycles, then re-pressed. Assert rst_ni mid-DETECT -> all outputs at
//    reset values immediately.

Source files
------------

// File: rtl/sysrst_ctrl_combo_multi.sv
// sysrst_ctrl_combo_multi
//
// Parametrised multi-combo key detector. Each of NumCombos detectors watches
// the keys selected by its mask. A detector fires once after the masked keys
// have been held for D+1 debounce cycles and then T+1 detect cycles. It then
// waits for release before it can fire again. Fires drive the system actions:
// sticky interrupt status, sticky battery disable, an EC reset low pulse and
// a one-cycle GSC reset pulse.
//
// Optional feature macro: SYSRST_CTRL_COMBO_PRECOND_EN
//   When defined, a precond_timer_i port is added. Each detector then arms
//   only after all of its keys have been released for precond_timer_i+1
//   cycles, both out of reset and after every disarm.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   keys_i              key levels, 1 = pressed
//   combo_sel_i         per-combo key mask (all-zero disables the combo)
//   debounce_timer_i    per-combo debounce length D
//   detect_timer_i      per-combo hold length T
//   combo_action_i      per combo {gsc_rst, ec_rst, bat_disable, intr}
//   ec_rst_pulse_i      EC reset low-pulse length P (low for P+1 cycles)
//   precond_timer_i     release time before arming (feature build only)
//   status_clr_i        write-1-to-clear for combo_status_o
//   combo_fire_o        one-cycle detection pulse per combo
//   combo_status_o      sticky status of interrupt-enabled combos
//   intr_o              OR of combo_status_o
//   bat_disable_o       sticky battery disable
//   ec_rst_l_o          active-low EC reset pulse
//   gsc_rst_o           one-cycle GSC reset pulse
module sysrst_ctrl_combo_multi #(
  parameter int NumKeys   = 5,
  parameter int NumCombos = 4,
  parameter int TimerW    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumKeys-1:0]            keys_i,
  input  logic [NumCombos*NumKeys-1:0]  combo_sel_i,
  input  logic [NumCombos*TimerW-1:0]   debounce_timer_i,
  input  logic [NumCombos*TimerW-1:0]   detect_timer_i,
  input  logic [NumCombos*4-1:0]        combo_action_i,
  input  logic [TimerW-1:0]             ec_rst_pulse_i,
`ifdef SYSRST_CTRL_COMBO_PRECOND_EN
  input  logic [TimerW-1:0]             precond_timer_i,
`endif
  input  logic [NumCombos-1:0]          status_clr_i,
  output logic [NumCombos-1:0]          combo_fire_o,
  output logic [NumCombos-1:0]          combo_status_o,
  output logic                          intr_o,
  output logic                          bat_disable_o,
  output logic                          ec_rst_l_o,
  output logic                          gsc_rst_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_DETECT   = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_PRECOND  = 3'd4
  } state_e;

  localparam logic [TimerW-1:0] ZERO = {TimerW{1'b0}};
  localparam logic [TimerW-1:0] ONE  = {{(TimerW-1){1'b0}}, 1'b1};

  // Disarming (and reset) lands in PRECOND when the feature is built in.
`ifdef SYSRST_CTRL_COMBO_PRECOND_EN
  localparam state_e ST_REARM = ST_PRECOND;
`else
  localparam state_e ST_REARM = ST_IDLE;
`endif

  logic [NumCombos-1:0] fire_s;
  logic [NumCombos-1:0] fire_r;
  logic [NumCombos-1:0] status_r;
  logic [NumCombos-1:0] status_s;
  logic [NumCombos-1:0] intr_set_s;
  logic                 intr_r;
  logic                 bat_r;
  logic                 bat_set_s;
  logic                 ec_set_s;
  logic                 gsc_set_s;
  logic                 gsc_r;
  logic                 ec_l_r;
  logic                 ec_l_s;
  logic [TimerW-1:0]    ec_cnt_r;
  logic [TimerW-1:0]    ec_cnt_s;

  for (genvar i = 0; i < NumCombos; i++) begin : g_combo
    logic [NumKeys-1:0] sel_s;
    logic [TimerW-1:0]  deb_s;
    logic [TimerW-1:0]  det_s;
    logic               active_s;
    logic               any_key_s;
    logic               combo_fire_s;
    state_e             state_r;
    state_e             state_s;
    logic [TimerW-1:0]  cnt_r;
    logic [TimerW-1:0]  cnt_s;

    assign sel_s     = combo_sel_i[i*NumKeys +: NumKeys];
    assign deb_s     = debounce_timer_i[i*TimerW +: TimerW];
    assign det_s     = detect_timer_i[i*TimerW +: TimerW];
    // Extra keys outside the mask are ignored; an empty mask never matches.
    assign active_s  = (sel_s != {NumKeys{1'b0}}) && ((keys_i & sel_s) == sel_s);
    assign any_key_s = ((keys_i & sel_s) != {NumKeys{1'b0}});
    assign fire_s[i] = combo_fire_s;

    // Detector next state: counters compare first and stop at their limit.
    always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      combo_fire_s = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (active_s) begin
            state_s = ST_DEBOUNCE;
            cnt_s   = ZERO;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (!active_s) begin
            state_s = ST_REARM;
            cnt_s   = ZERO;
          end else if (cnt_r == deb_s) begin
            state_s = ST_DETECT;
            cnt_s   = ZERO;
          end else begin
            cnt_s   = cnt_r + ONE;
          end
        end
        ST_DETECT: begin
          if (!active_s) begin
            state_s = ST_REARM;
            cnt_s   = ZERO;
          end else if (cnt_r == det_s) begin
            state_s      = ST_WAIT_REL;
            combo_fire_s = 1'b1;
          end else begin
            cnt_s   = cnt_r + ONE;
          end
        end
        ST_WAIT_REL: begin
          if (!active_s) begin
            state_s = ST_REARM;
            cnt_s   = ZERO;
          end else begin
            state_s = ST_WAIT_REL;
          end
        end
`ifdef SYSRST_CTRL_COMBO_PRECOND_EN
        ST_PRECOND: begin
          // Any masked key still down restarts the release window.
          if (any_key_s) begin
            cnt_s = ZERO;
          end else if (cnt_r == precond_timer_i) begin
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + ONE;
          end
        end
`endif
        default: begin
          state_s = ST_REARM;
          cnt_s   = ZERO;
        end
      endcase
    end

    // Detector state and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_r <= ST_REARM;
        cnt_r   <= ZERO;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
      end
    end
  end

  // Gather the actions of all registered fires; simultaneous fires OR together.
  always_comb begin
    intr_set_s = {NumCombos{1'b0}};
    bat_set_s  = 1'b0;
    ec_set_s   = 1'b0;
    gsc_set_s  = 1'b0;
    for (int i = 0; i < NumCombos; i++) begin
      intr_set_s[i] = fire_r[i] & combo_action_i[4*i];
      bat_set_s     = bat_set_s | (fire_r[i] & combo_action_i[4*i+1]);
      ec_set_s      = ec_set_s  | (fire_r[i] & combo_action_i[4*i+2]);
      gsc_set_s     = gsc_set_s | (fire_r[i] & combo_action_i[4*i+3]);
    end
    // A set in the same cycle as a clear wins.
    status_s = (status_r & ~status_clr_i) | intr_set_s;
  end

  // EC reset pulse: a new request reloads the count even mid-pulse.
  always_comb begin
    ec_l_s   = ec_l_r;
    ec_cnt_s = ec_cnt_r;
    if (ec_set_s) begin
      ec_l_s   = 1'b0;
      ec_cnt_s = ec_rst_pulse_i;
    end else if (!ec_l_r) begin
      if (ec_cnt_r == ZERO) begin
        ec_l_s = 1'b1;
      end else begin
        ec_cnt_s = ec_cnt_r - ONE;
      end
    end else begin
      ec_l_s = 1'b1;
    end
  end

  // Output and action registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fire_r   <= {NumCombos{1'b0}};
      status_r <= {NumCombos{1'b0}};
      intr_r   <= 1'b0;
      bat_r    <= 1'b0;
      gsc_r    <= 1'b0;
      ec_l_r   <= 1'b1;
      ec_cnt_r <= ZERO;
    end else begin
      fire_r   <= fire_s;
      status_r <= status_s;
      intr_r   <= |status_s;
      bat_r    <= bat_r | bat_set_s;
      gsc_r    <= gsc_set_s;
      ec_l_r   <= ec_l_s;
      ec_cnt_r <= ec_cnt_s;
    end
  end

  assign combo_fire_o   = fire_r;
  assign combo_status_o = status_r;
  assign intr_o         = intr_r;
  assign bat_disable_o  = bat_r;
  assign ec_rst_l_o     = ec_l_r;
  assign gsc_rst_o      = gsc_r;

endmodule

// File: tb/tb_sysrst_ctrl_combo_multi.sv
// Self-checking bench for sysrst_ctrl_combo_multi: reset values, a table of
// single-combo timing vectors, hand sequences for the multi-cycle corners and
// randomized phases compared every cycle against a run-length reference model.
module tb_sysrst_ctrl_combo_multi;
  localparam int NK = 5;
  localparam int NC = 4;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [NK-1:0] keys;
  logic [NK-1:0] sel_a [NC];
  logic [TW-1:0] d_a [NC];
  logic [TW-1:0] t_a [NC];
  logic [3:0]    act_a [NC];
  logic [TW-1:0] pulse;
  logic [TW-1:0] precond;
  logic [NC-1:0] clr;
  logic [NC*NK-1:0] sel_f;
  logic [NC*TW-1:0] d_f, t_f;
  logic [NC*4-1:0]  act_f;
  logic [NC-1:0] fire_o, status_o;
  logic intr_o, bat_o, ec_l_o, gsc_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_flat
    assign sel_f[g*NK +: NK] = sel_a[g];
    assign d_f[g*TW +: TW]   = d_a[g];
    assign t_f[g*TW +: TW]   = t_a[g];
    assign act_f[g*4 +: 4]   = act_a[g];
  end

  sysrst_ctrl_combo_multi #(.NumKeys(NK), .NumCombos(NC), .TimerW(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .keys_i(keys), .combo_sel_i(sel_f),
    .debounce_timer_i(d_f), .detect_timer_i(t_f), .combo_action_i(act_f),
    .ec_rst_pulse_i(pulse),
`ifdef SYSRST_CTRL_COMBO_PRECOND_EN
    .precond_timer_i(precond),
`endif
    .status_clr_i(clr), .combo_fire_o(fire_o), .combo_status_o(status_o),
    .intr_o(intr_o), .bat_disable_o(bat_o), .ec_rst_l_o(ec_l_o), .gsc_rst_o(gsc_o));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A combo fires when its keys have been continuously matched for D+T+3
  // sampled edges; actions appear one edge after the fire.
  int run_m [NC];
  logic [NC-1:0] fire_m, stat_m;
  logic intr_m, bat_m, gsc_m;
  int rem_m;

  function automatic logic [NC-1:0] amask(input int b);
    logic [NC-1:0] m;
    for (int i = 0; i < NC; i++) m[i] = act_a[i][b];
    return m;
  endfunction

  function automatic bit matched(input int i);
    return (sel_a[i] != '0) && ((keys & sel_a[i]) == sel_a[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) run_m[i] <= 0;
      fire_m <= '0; stat_m <= '0; intr_m <= 1'b0; bat_m <= 1'b0; gsc_m <= 1'b0; rem_m <= 0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        run_m[i]  <= matched(i) ? run_m[i] + 1 : 0;
        fire_m[i] <= matched(i) && (run_m[i] + 1 == int'(d_a[i]) + int'(t_a[i]) + 3);
      end
      stat_m <= (stat_m & ~clr) | (fire_m & amask(0));
      intr_m <= |((stat_m & ~clr) | (fire_m & amask(0)));
      bat_m  <= bat_m | (|(fire_m & amask(1)));
      gsc_m  <= |(fire_m & amask(3));
      if (|(fire_m & amask(2))) rem_m <= int'(pulse) + 1;
      else if (rem_m > 0)       rem_m <= rem_m - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_fire",   32'(fire_o),   32'(fire_m));
      chk("m_status", 32'(status_o), 32'(stat_m));
      chk("m_intr",   32'(intr_o),   32'(intr_m));
      chk("m_bat",    32'(bat_o),    32'(bat_m));
      chk("m_ec_l",   32'(ec_l_o),   32'(rem_m == 0));
      chk("m_gsc",    32'(gsc_o),    32'(gsc_m));
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    string         nm;
    logic [NK-1:0] sel;
    logic [TW-1:0] d;
    logic [TW-1:0] t;
    logic [3:0]    act;
    logic [NK-1:0] k;
    int            hold;
    int            exp_cyc;
  } vec_t;

  task automatic clear_cfg();
    for (int i = 0; i < NC; i++) begin
      sel_a[i] = '0; d_a[i] = '0; t_a[i] = '0; act_a[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    keys = '0;
    clr  = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fire"},   32'(fire_o),   32'd0);
    chk({tag, "_status"}, 32'(status_o), 32'd0);
    chk({tag, "_intr"},   32'(intr_o),   32'd0);
    chk({tag, "_bat"},    32'(bat_o),    32'd0);
    chk({tag, "_ec_l"},   32'(ec_l_o),   32'd1);
    chk({tag, "_gsc"},    32'(gsc_o),    32'd0);
  endtask

  vec_t vecs [9];
  int first, cnt_a, cnt_b;

  initial begin
    vecs[0] = '{"basic_d3t5",    5'b00011, 16'd3, 16'd5, 4'b0001, 5'b00011, 14, 10};
    vecs[1] = '{"early_release", 5'b00011, 16'd3, 16'd5, 4'b0001, 5'b00011,  6, -1};
    vecs[2] = '{"restart",       5'b00011, 16'd3, 16'd5, 4'b0001, 5'b00011, 14, 10};
    vecs[3] = '{"extra_keys",    5'b00011, 16'd0, 16'd0, 4'b0000, 5'b11111,  5,  2};
    vecs[4] = '{"disabled",      5'b00000, 16'd0, 16'd0, 4'b0001, 5'b11111,  8, -1};
    vecs[5] = '{"partial",       5'b10100, 16'd0, 16'd0, 4'b0001, 5'b00100,  8, -1};
    vecs[6] = '{"d1t2",          5'b00001, 16'd1, 16'd2, 4'b0000, 5'b00001,  9,  5};
    vecs[7] = '{"zero_short",    5'b00001, 16'd0, 16'd0, 4'b0000, 5'b00001,  2, -1};
    vecs[8] = '{"zero_exact",    5'b00001, 16'd0, 16'd0, 4'b0000, 5'b00001,  3,  2};

    rst_n = 1'b1; keys = '0; clr = '0; pulse = '0; precond = '0;
    clear_cfg();
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Table-driven single-combo timing.
    foreach (vecs[v]) begin
      clear_cfg();
      sel_a[0] = vecs[v].sel; d_a[0] = vecs[v].d; t_a[0] = vecs[v].t; act_a[0] = vecs[v].act;
      keys = vecs[v].k;
      first = -1;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (fire_o[0] && first < 0) first = c;
        if (c == vecs[v].hold - 1) keys = '0;
      end
      chk(vecs[v].nm, 32'(first), 32'(vecs[v].exp_cyc));
      idle(2);
    end

    // Clear in the same cycle as a new set: the set wins.
    clear_cfg();
    sel_a[0] = 5'b00011; act_a[0] = 4'b0001;
    keys = 5'b00011;
    first = -1;
    for (int c = 0; c < 8 && first < 0; c++) begin
      @(negedge clk);
      if (fire_o[0]) first = c;
    end
    chk("clr_fire_seen", 32'(first), 32'd2);
    clr[0] = 1'b1;
    @(negedge clk);
    clr = '0;
    chk("clr_vs_set", 32'(status_o[0]), 32'd1);
    keys = '0;
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr = '0;
    chk("clr_alone", 32'(status_o[0]), 32'd0);
    chk("clr_intr", 32'(intr_o), 32'd0);
    idle(2);

    // EC pulse restarted two cycles in: 2 + (P+1) low cycles.
    clear_cfg();
    pulse = 16'd4;
    sel_a[0] = 5'b00001; act_a[0] = 4'b0100;
    sel_a[1] = 5'b00010; act_a[1] = 4'b0100; d_a[1] = 16'd2;
    keys = 5'b00011;
    cnt_a = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!ec_l_o) cnt_a++;
    end
    chk("ec_low_cycles", 32'(cnt_a), 32'd7);
    idle(2);

    // Two combos firing together: bat sticky, gsc single pulse.
    clear_cfg();
    sel_a[0] = 5'b00001; act_a[0] = 4'b0010;
    sel_a[1] = 5'b00011; act_a[1] = 4'b1000;
    keys = 5'b00011;
    first = -1; cnt_b = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fire_o[1:0] == 2'b11 && first < 0) first = c;
      if (gsc_o) cnt_b++;
    end
    chk("dual_fire_cycle", 32'(first), 32'd2);
    chk("gsc_pulses", 32'(cnt_b), 32'd1);
    idle(3);
    chk("bat_sticky", 32'(bat_o), 32'd1);

    // Asynchronous reset while combo 0 is in DETECT and the EC pulse is low.
    clear_cfg();
    pulse = 16'd20;
    sel_a[0] = 5'b00001; t_a[0] = 16'd9; act_a[0] = 4'b0001;
    sel_a[1] = 5'b00010; act_a[1] = 4'b0100;
    keys = 5'b00011;
    repeat (6) @(negedge clk);
    chk("pre_rst_ec_low", 32'(ec_l_o), 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    keys = '0;
    rst_n = 1'b1;
    idle(2);

`ifdef SYSRST_CTRL_COMBO_PRECOND_EN
    // Keys held from reset: no fire until released precond+1 cycles.
    chk_en = 1'b0;
    clear_cfg();
    sel_a[0] = 5'b00001; act_a[0] = 4'b0001;
    precond = 16'd3;
    keys = 5'b00001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0;
    repeat (10) begin
      @(negedge clk);
      if (fire_o[0]) cnt_a++;
    end
    chk("precond_held", 32'(cnt_a), 32'd0);
    keys = '0;
    repeat (4) @(negedge clk);
    keys = 5'b00001;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fire_o[0] && first < 0) first = c;
    end
    chk("precond_armed", 32'(first), 32'd2);
`else
    // Randomized phases compared every cycle against the model.
    for (int ph = 0; ph < 40; ph++) begin
      for (int i = 0; i < NC; i++) begin
        sel_a[i] = ($urandom_range(0, 3) == 0) ? '0 : NK'($urandom_range(1, 31));
        d_a[i]   = TW'($urandom_range(0, 3));
        t_a[i]   = TW'($urandom_range(0, 3));
        act_a[i] = 4'($urandom_range(0, 15));
      end
      pulse = TW'($urandom_range(0, 5));
      for (int c = 0; c < 30; c++) begin
        if ($urandom_range(0, 7) == 0) keys = sel_a[$urandom_range(0, NC-1)] | NK'($urandom_range(0, 31));
        else if ($urandom_range(0, 3) == 0) keys = keys ^ NK'(1 << $urandom_range(0, NK-1));
        clr = ($urandom_range(0, 7) == 0) ? NC'($urandom_range(0, 15)) : '0;
        @(negedge clk);
      end
      idle(2);
      if (ph % 10 == 9) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
      end
    end
`endif

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
